vip_group_argmax: RTL



---
 rtl/vip_pkg.sv | 17 +
 rtl/vip_fp_key.sv | 19 +
 rtl/vip_group_argmax.sv | 124 ++++++++++++
 3 files changed

// File: rtl/vip_pkg.sv
// Shared types and defaults for the vector inner-product pipeline.
// The fp word width and the group FSM states live here.
package vip_pkg;

    localparam int DEF_SIG_WIDTH = 23;
    localparam int DEF_EXP_WIDTH = 8;
    localparam int FP_W = DEF_SIG_WIDTH + DEF_EXP_WIDTH + 1;

    typedef logic [FP_W-1:0] fp_t;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DONE
    } state_t;

endpackage

// File: rtl/vip_fp_key.sv
// Maps an IEEE-754 bit pattern to an unsigned key with the same ordering.
// Positive values get the MSB set; negative values are bit-inverted.
module vip_fp_key #(
    parameter int W = 32
) (
    input  logic [W-1:0] data,
    output logic [W-1:0] key
);

    always_comb begin
        key = data;
        if (data[W-1]) begin
            key = ~data;
        end else begin
            key[W-1] = 1'b1;
        end
    end

endmodule

// File: rtl/vip_group_argmax.sv
// Groups GROUP consecutive fp samples and reports max, min and argmax
// as a registered one-cycle pulse.
module vip_group_argmax
    import vip_pkg::*;
#(
    parameter int SIG_WIDTH = DEF_SIG_WIDTH,
    parameter int EXP_WIDTH = DEF_EXP_WIDTH,
    parameter int GROUP     = 4,
    parameter int IDX_W     = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [SIG_WIDTH+EXP_WIDTH:0] in_data,
    input  logic                         clear,
    output logic                         out_valid,
    output logic [SIG_WIDTH+EXP_WIDTH:0] out_max,
    output logic [SIG_WIDTH+EXP_WIDTH:0] out_min,
    output logic [IDX_W-1:0]             out_idx
);

    localparam int W = SIG_WIDTH + EXP_WIDTH + 1;

    state_t state, state_nxt;

    logic [IDX_W-1:0] cnt;
    logic [W-1:0]     max_r, min_r, min_key_r;
    logic [IDX_W-1:0] idx_r;

    logic [W-1:0]     key_s, key_max;
    logic [W-1:0]     max_nxt, min_nxt, min_key_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic             first, last;

    vip_fp_key #(.W(W)) u_key_smp (
        .data (in_data),
        .key  (key_s)
    );

    vip_fp_key #(.W(W)) u_key_max (
        .data (max_r),
        .key  (key_max)
    );

    // clear with a coincident sample restarts the group at that sample
    assign first = clear || (state != COLLECT);
    assign last  = in_valid && !first && (cnt == IDX_W'(GROUP - 1));

    always_comb begin
        max_nxt     = max_r;
        idx_nxt     = idx_r;
        min_nxt     = min_r;
        min_key_nxt = min_key_r;
        if (first) begin
            max_nxt     = in_data;
            idx_nxt     = '0;
            min_nxt     = in_data;
            min_key_nxt = key_s;
        end else begin
            if (key_s > key_max) begin
                max_nxt = in_data;
                idx_nxt = cnt;
            end
            if (key_s < min_key_r) begin
                min_nxt     = in_data;
                min_key_nxt = key_s;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (last) begin
            state_nxt = DONE;
        end else if (in_valid) begin
            state_nxt = COLLECT;
        end else if (clear || state == DONE) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            max_r     <= '0;
            min_r     <= '0;
            min_key_r <= '0;
            idx_r     <= '0;
            out_valid <= 1'b0;
            out_max   <= '0;
            out_min   <= '0;
            out_idx   <= '0;
        end else begin
            if (in_valid) begin
                max_r     <= max_nxt;
                min_r     <= min_nxt;
                min_key_r <= min_key_nxt;
                idx_r     <= idx_nxt;
                if (last) begin
                    cnt <= '0;
                end else if (first) begin
                    cnt <= IDX_W'(1);
                end else begin
                    cnt <= cnt + IDX_W'(1);
                end
            end else if (clear) begin
                cnt <= '0;
            end
            out_valid <= last;
            out_max   <= last ? max_nxt : '0;
            out_min   <= last ? min_nxt : '0;
            out_idx   <= last ? idx_nxt : '0;
        end
    end

endmodule
